axi4_slave_mem: RTL and testbench

//  AXI4 memory responder, the subordinate end of the axi4_master_fsm link.

---
 rtl/axi4_slave_mem_if.sv | 46 ++++
 rtl/axi4_slave_mem.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle (no IDs) joining a master to the axi4_slave_mem responder.
interface axi4_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rlast, rresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rlast, rresp
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 memory responder: independent single-transaction write and read FSMs
// over one word-addressed array, with SLVERR injection for exercising masters.
module axi4_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic            clk,
    input  logic            rst,
    axi4_slave_mem_if.slave bus,
    input  logic            err_inject_w,
    input  logic            err_inject_r
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SH    = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0] SIZE_OK     = 3'(SH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;

    function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != SIZE_OK) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> SH;
        return (addr >= BASE_ADDR) && (word < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> SH);
    endfunction

    // WRAP keeps the bits above the container and wraps the offset inside it.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] nxt;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << SH) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   nxt = addr;
            2'b10:   nxt = (addr & ~mask) | ((addr + STEP) & mask);
            default: nxt = addr + STEP;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e              w_state, w_state_n;
    logic [7:0]            w_beat, w_beat_n;
    logic                  w_err, w_err_n, w_last_beat;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_n;
    logic [7:0]            w_len, w_len_n;
    logic [1:0]            w_burst, w_burst_n;
    logic                  awready, awready_n, wready, wready_n, bvalid, bvalid_n;
    logic [1:0]            bresp, bresp_n;
    logic                  mem_we;

    r_state_e              r_state, r_state_n;
    logic [7:0]            r_beat, r_beat_n;
    logic                  r_err, r_err_n;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_n;
    logic [7:0]            r_len, r_len_n;
    logic [1:0]            r_burst, r_burst_n;
    logic                  arready, arready_n, rvalid, rvalid_n, rlast, rlast_n;
    logic [1:0]            rresp, rresp_n;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_load, rd_ok;
    logic [ADDR_WIDTH-1:0] rd_addr;

    always_comb begin
        w_state_n   = w_state;
        w_beat_n    = w_beat;
        w_err_n     = w_err;
        w_addr_n    = w_addr;
        w_len_n     = w_len;
        w_burst_n   = w_burst;
        awready_n   = awready;
        wready_n    = wready;
        bvalid_n    = bvalid;
        bresp_n     = bresp;
        mem_we      = 1'b0;
        w_last_beat = (w_beat == w_len);
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (bus.awvalid && awready) begin
                    w_addr_n  = bus.awaddr;
                    w_len_n   = bus.awlen;
                    w_burst_n = bus.awburst;
                    w_beat_n  = '0;
                    w_err_n   = err_inject_w || cfg_err(bus.awsize, bus.awburst, bus.awlen);
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid && wready) begin
                    mem_we  = !w_err && in_range(w_addr);
                    w_err_n = w_err || !in_range(w_addr) || (bus.wlast != w_last_beat);
                    // An early wlast closes the burst just like the final beat does.
                    if (w_last_beat || bus.wlast) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bresp_n   = w_err_n ? RESP_SLVERR : RESP_OKAY;
                        w_state_n = W_RESP;
                    end else begin
                        w_beat_n = w_beat + 8'd1;
                        w_addr_n = next_addr(w_addr, w_burst, w_len);
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bus.bready) begin
                    bvalid_n  = 1'b0;
                    bresp_n   = RESP_OKAY;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_n = r_state;
        r_beat_n  = r_beat;
        r_err_n   = r_err;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_burst_n = r_burst;
        arready_n = arready;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rresp_n   = rresp;
        rd_load   = 1'b0;
        rd_ok     = 1'b0;
        rd_addr   = r_addr;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (bus.arvalid && arready) begin
                    r_addr_n  = bus.araddr;
                    r_len_n   = bus.arlen;
                    r_burst_n = bus.arburst;
                    r_beat_n  = '0;
                    r_err_n   = err_inject_r || cfg_err(bus.arsize, bus.arburst, bus.arlen);
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rlast_n   = (bus.arlen == 8'd0);
                    rd_load   = 1'b1;
                    rd_addr   = bus.araddr;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && bus.rready) begin
                    rd_load = 1'b1;
                    if (rlast) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        r_beat_n = r_beat + 8'd1;
                        r_addr_n = next_addr(r_addr, r_burst, r_len);
                        rd_addr  = r_addr_n;
                        rlast_n  = (r_beat_n == r_len);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        // Errored or out-of-range beats still complete, carrying zero data.
        if (rd_load) begin
            rd_ok   = rvalid_n && !r_err_n && in_range(rd_addr);
            rresp_n = (rvalid_n && !rd_ok) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            r_state <= R_IDLE;
            r_beat  <= '0;
            r_err   <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
        end else begin
            w_state <= w_state_n;
            w_beat  <= w_beat_n;
            w_err   <= w_err_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
            r_state <= r_state_n;
            r_beat  <= r_beat_n;
            r_err   <= r_err_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            rresp   <= rresp_n;
        end
    end

    // Burst context and array contents survive reset; only the commit is held off.
    always_ff @(posedge clk) begin
        w_addr  <= w_addr_n;
        w_len   <= w_len_n;
        w_burst <= w_burst_n;
        r_addr  <= r_addr_n;
        r_len   <= r_len_n;
        r_burst <= r_burst_n;
        if (mem_we && !rst) begin
            mem[word_idx(w_addr)] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_load) begin
            rdata <= rd_ok ? mem[word_idx(rd_addr)] : '0;
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rlast   = rlast;
    assign bus.rresp   = rresp;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomised bench for axi4_slave_mem against a burst-level memory model.
module tb_axi4_slave_mem;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DEPTH = 2048;
    localparam int BYTES = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_inject_w = 1'b0;
    logic err_inject_r = 1'b0;

    axi4_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .err_inject_w(err_inject_w), .err_inject_r(err_inject_r)
    );

    always #5 clk = ~clk;

    logic [63:0] model_mem [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cfg_ok(input logic [2:0] size, input logic [1:0] burst, input int len);
        if (size != 3'd3 || burst == 2'b11) return 1'b0;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return longint'(a) < longint'(DEPTH * BYTES);
    endfunction

    // Byte address of beat i, straight from the AXI burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        longint s, cont, base;
        s = longint'(start);
        case (burst)
            2'b00: return start;
            2'b10: begin
                cont = longint'(len + 1) * BYTES;
                base = s - (s % cont);
                return 32'(base + ((s - base + longint'(i) * BYTES) % cont));
            end
            default: return 32'(s + longint'(i) * BYTES);
        endcase
    endfunction

    function automatic bit sig_hi(input int which);
        case (which)
            0: return bus.awready;
            1: return bus.wready;
            default: return bus.arready;
        endcase
    endfunction

    task automatic wait_hi(input int which, input string tag, output bit ok);
        int n;
        n = 0;
        while (!sig_hi(which) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = sig_hi(which);
        if (!ok) check_val({tag, "_timeout"}, 64'(sig_hi(which)), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input bit inject, input int last_at,
                            input logic [63:0] base, input bit rnd, input string tag);
        logic [63:0] d [256];
        logic [31:0] a;
        bit err, inr, ok;
        int nbeats;
        logic [1:0] exp_resp;
        for (int i = 0; i < 256; i++) d[i] = rnd ? {$urandom, $urandom} : base + 64'(i);
        err = inject || !cfg_ok(size, burst, len);
        nbeats = ((last_at < len) ? last_at : len) + 1;
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, len, burst, i);
            inr = addr_ok(a);
            if (!err && inr) model_mem[a[13:3]] = d[i];
            if (!inr || ((i == last_at) != (i == len))) err = 1'b1;
        end
        exp_resp = err ? 2'b10 : 2'b00;

        bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1; err_inject_w = inject;
        wait_hi(0, {tag, "_aw"}, ok);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; err_inject_w = 1'b0;
        if (!ok) return;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            bus.wvalid = 1'b1; bus.wdata = d[i]; bus.wlast = (i == last_at);
            wait_hi(1, {tag, "_w"}, ok);
            @(posedge clk); #1;
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
            if (!ok) return;
        end
        check_val({tag, "_bvalid_wready"}, {bus.bvalid, bus.wready}, 2'b10);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            check_val({tag, "_b_hold"}, {bus.bvalid, bus.bresp}, {1'b1, exp_resp});
        end
        check_val({tag, "_bresp"}, bus.bresp, exp_resp);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check_val({tag, "_b_done"}, {bus.bvalid, bus.awready}, 2'b01);
    endtask

    // mode 0: rready always high, 1: toggles starting low, 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input bit inject, input int mode,
                           input string tag);
        logic [31:0] a;
        logic [63:0] expd;
        bit cerr, bad, rdy, ok;
        int got, cyc;
        cerr = inject || !cfg_ok(size, burst, len);
        bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1; err_inject_r = inject;
        wait_hi(2, {tag, "_ar"}, ok);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; err_inject_r = 1'b0;
        if (!ok) return;
        got = 0;
        cyc = 0;
        while (got <= len && cyc < 4 * (len + 1) + 8) begin
            check_val({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
            if (!bus.rvalid) break;
            a = beat_addr(addr, len, burst, got);
            bad = cerr || !addr_ok(a);
            expd = bad ? 64'd0 : model_mem[a[13:3]];
            check_val({tag, "_rdata"}, bus.rdata, expd);
            check_val({tag, "_rresp_rlast"}, {bus.rresp, bus.rlast},
                      {(bad ? 2'b10 : 2'b00), (got == len)});
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'(($urandom_range(0, 1)));
            endcase
            bus.rready = rdy;
            @(posedge clk); #1;
            bus.rready = 1'b0;
            if (rdy) got++;
            cyc++;
        end
        check_val({tag, "_beats"}, 64'(got), 64'(len + 1));
        check_val({tag, "_r_done"}, {bus.rvalid, bus.arready}, 2'b01);
    endtask

    function automatic logic [1:0] rand_burst();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 2'b01;
        if (r < 7) return 2'b10;
        if (r < 9) return 2'b00;
        return 2'b11;
    endfunction

    function automatic int rand_len(input logic [1:0] burst);
        int pick;
        if (burst == 2'b10 && $urandom_range(0, 4) != 0) begin
            pick = $urandom_range(0, 3);
            return (2 << pick) - 1;
        end
        return $urandom_range(0, 15);
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [1:0] b, b2;
        int l, l2;
        bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
                                 bus.rvalid, bus.rlast, bus.rresp}, 64'd0);
        check_val("reset_rdata", bus.rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("reset_release_ready", {bus.awready, bus.arready}, 2'b11);

        for (int k = 0; k < DEPTH / 256; k++)
            do_write(32'(k * 256 * BYTES), 255, 2'b01, 3'd3, 1'b0, 255, 64'd0, 1'b1, "fill");

        do_write(32'h1000, 7, 2'b01, 3'd3, 1'b0, 7, 64'hA0, 1'b0, "incr_wr");
        do_read(32'h1000, 7, 2'b01, 3'd3, 1'b0, 0, "incr_rd");
        do_read(32'h1000, 7, 2'b01, 3'd3, 1'b0, 1, "stall_rd");

        do_write(32'h2000, 3, 2'b01, 3'd3, 1'b1, 3, 64'h5500, 1'b0, "inj_wr");
        do_read(32'h2000, 3, 2'b01, 3'd3, 1'b0, 2, "inj_chk");
        do_write(32'h2000, 3, 2'b01, 3'd3, 1'b0, 3, 64'h5500, 1'b0, "retry_wr");
        do_read(32'h2000, 3, 2'b01, 3'd3, 1'b0, 2, "retry_rd");

        do_read(32'h1018, 3, 2'b10, 3'd3, 1'b0, 0, "wrap_rd");
        do_read(32'h1018, 2, 2'b10, 3'd3, 1'b0, 0, "wrap_badlen");
        do_read(32'(DEPTH * BYTES), 1, 2'b01, 3'd3, 1'b0, 0, "oor_rd");
        do_read(32'h1000, 3, 2'b01, 3'd3, 1'b1, 2, "inj_rd");

        do_write(32'h3FF0, 3, 2'b01, 3'd3, 1'b0, 3, 64'hE0, 1'b0, "edge_wr");
        do_read(32'h3FF0, 3, 2'b01, 3'd3, 1'b0, 0, "edge_rd");
        do_write(32'h0800, 3, 2'b00, 3'd3, 1'b0, 3, 64'hF0, 1'b0, "fixed_wr");
        do_read(32'h0800, 1, 2'b01, 3'd3, 1'b0, 0, "fixed_rd");
        do_write(32'h0900, 5, 2'b01, 3'd3, 1'b0, 2, 64'hB0, 1'b0, "early_wlast");
        do_write(32'h0A00, 2, 2'b01, 3'd2, 1'b0, 2, 64'hD0, 1'b0, "badsize_wr");
        do_read(32'h0900, 5, 2'b01, 3'd3, 1'b0, 0, "post_err_rd");

        // Reset in the middle of a write burst, after three committed beats.
        bus.awaddr = 32'h3000; bus.awlen = 8'd7; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        wait_hi(0, "rst_aw", ok);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wvalid = 1'b1; bus.wdata = 64'hC0 + 64'(i); bus.wlast = 1'b0;
            wait_hi(1, "rst_w", ok);
            @(posedge clk); #1;
            bus.wvalid = 1'b0;
            model_mem[11'(32'h3000 / BYTES + i)] = 64'hC0 + 64'(i);
        end
        bus.wvalid = 1'b1; bus.wdata = 64'hDEAD;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_outs", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
                                   bus.rvalid, bus.rlast, bus.rresp}, 64'd0);
        check_val("rst_mid_rdata", bus.rdata, 64'd0);
        bus.wvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_mid_release", {bus.awready, bus.arready, bus.bvalid}, 3'b110);
        do_read(32'h3000, 3, 2'b01, 3'd3, 1'b0, 0, "rst_kept");

        for (int t = 0; t < 40; t++) begin
            b = rand_burst();
            l = rand_len(b);
            case ($urandom_range(0, 2))
                0: do_write(32'($urandom_range(0, DEPTH + 4)) << 3, l, b,
                            ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3,
                            $urandom_range(0, 9) == 0, l, 64'd0, 1'b1, "rnd_wr");
                1: do_read(32'($urandom_range(0, DEPTH + 4)) << 3, l, b,
                           ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3,
                           $urandom_range(0, 9) == 0, 2, "rnd_rd");
                default: begin
                    b2 = rand_burst();
                    l2 = rand_len(b2);
                    fork
                        do_write(32'($urandom_range(0, 960)) << 3, l, b, 3'd3,
                                 $urandom_range(0, 9) == 0, l, 64'd0, 1'b1, "cc_wr");
                        do_read(32'($urandom_range(1024, 1984)) << 3, l2, b2, 3'd3,
                                $urandom_range(0, 9) == 0, 2, "cc_rd");
                    join
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
